led_pulse_stretcher: RTL and testbench

//  Output-side counterpart to switch input conditioning. It turns short internal event strobes into LED pulses

---
 rtl/led_pulse_stretcher_if.sv | 30 +++
 rtl/led_pulse_stretcher.sv | 127 ++++++++++++
 tb/tb_led_pulse_stretcher.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/led_pulse_stretcher_if.sv
// Signal bundle between core status strobes and the LED pulse stretcher.
// All signals are plain levels sampled on clk; there is no valid/ready handshake.
interface led_pulse_stretcher_if #(
   parameter int C_CHANNELS = 4
);
   logic [C_CHANNELS-1:0]   i_event;
   logic                    i_clr_overflow;
   logic [C_CHANNELS-1:0]   o_led;
   logic [C_CHANNELS-1:0]   o_busy;
   logic [C_CHANNELS-1:0]   o_overflow;
   logic [2*C_CHANNELS-1:0] o_dbg_state;

   modport master (
      output i_event,
      output i_clr_overflow,
      input  o_led,
      input  o_busy,
      input  o_overflow,
      input  o_dbg_state
   );

   modport slave (
      input  i_event,
      input  i_clr_overflow,
      output o_led,
      output o_busy,
      output o_overflow,
      output o_dbg_state
   );
endinterface

// File: rtl/led_pulse_stretcher.sv
// Stretches short event strobes into visible LED blinks with a guaranteed on-time and off-gap.
// Each channel runs IDLE -> ON -> GAP with a one-deep pending slot; o_dbg_state exposes 2 bits per channel.
module led_pulse_stretcher #(
   parameter int C_CHANNELS  = 4,
   parameter int C_ON_TICKS  = 2500000,
   parameter int C_OFF_TICKS = 1250000,
   parameter int C_CNT_WIDTH = 22,
   parameter bit C_EDGE      = 1'b1
) (
   input logic clk,
   input logic i_rst,
   led_pulse_stretcher_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [C_CNT_WIDTH-1:0] ON_LAST  = C_CNT_WIDTH'(C_ON_TICKS - 1);
   localparam logic [C_CNT_WIDTH-1:0] OFF_LAST = C_CNT_WIDTH'(C_OFF_TICKS - 1);
   localparam logic [C_CNT_WIDTH-1:0] CNT_ONE  = C_CNT_WIDTH'(1);
   localparam logic [C_CNT_WIDTH-1:0] CNT_ZERO = '0;

   state_t                 state_q [C_CHANNELS];
   state_t                 state_d [C_CHANNELS];
   logic [C_CNT_WIDTH-1:0] cnt_q   [C_CHANNELS];
   logic [C_CNT_WIDTH-1:0] cnt_d   [C_CHANNELS];
   logic [C_CHANNELS-1:0]  pend_q, pend_d;
   logic [C_CHANNELS-1:0]  prev_q;
   logic [C_CHANNELS-1:0]  ev;
   logic [C_CHANNELS-1:0]  led_q, led_d;
   logic [C_CHANNELS-1:0]  busy_q, busy_d;
   logic [C_CHANNELS-1:0]  ovf_q, ovf_d;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         for (int k = 0; k < C_CHANNELS; k++) begin
            state_q[k] <= ST_IDLE;
            cnt_q[k]   <= CNT_ZERO;
         end
         pend_q <= '0;
         prev_q <= '0;
         led_q  <= '0;
         busy_q <= '0;
         ovf_q  <= '0;
      end else begin
         for (int k = 0; k < C_CHANNELS; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         pend_q <= pend_d;
         prev_q <= bus.i_event;
         led_q  <= led_d;
         busy_q <= busy_d;
         ovf_q  <= ovf_d;
      end
   end

   always_comb begin
      ev      = C_EDGE ? (bus.i_event & ~prev_q) : bus.i_event;
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      // Clear first so a new overflow in the same cycle wins.
      ovf_d   = bus.i_clr_overflow ? '0 : ovf_q;
      led_d   = '0;
      busy_d  = '0;
      for (int k = 0; k < C_CHANNELS; k++) begin
         case (state_q[k])
            ST_ON: begin
               if (ev[k]) begin
                  if (pend_q[k]) ovf_d[k] = 1'b1;
                  else           pend_d[k] = 1'b1;
               end
               if (cnt_q[k] == ON_LAST) begin
                  state_d[k] = ST_GAP;
                  cnt_d[k]   = CNT_ZERO;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_ONE;
               end
            end
            ST_GAP: begin
               if (cnt_q[k] == OFF_LAST) begin
                  // Last gap cycle: a queued or fresh event restarts with no idle cycle.
                  if (pend_q[k] || ev[k]) begin
                     state_d[k] = ST_ON;
                     cnt_d[k]   = CNT_ZERO;
                     pend_d[k]  = 1'b0;
                     if (pend_q[k] && ev[k]) ovf_d[k] = 1'b1;
                  end else begin
                     state_d[k] = ST_IDLE;
                     cnt_d[k]   = CNT_ZERO;
                  end
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_ONE;
                  if (ev[k]) begin
                     if (pend_q[k]) ovf_d[k] = 1'b1;
                     else           pend_d[k] = 1'b1;
                  end
               end
            end
            default: begin
               if (ev[k]) begin
                  state_d[k] = ST_ON;
                  cnt_d[k]   = CNT_ZERO;
               end
            end
         endcase
         led_d[k]  = (state_d[k] == ST_ON);
         busy_d[k] = (state_d[k] != ST_IDLE);
      end
   end

   always_comb begin
      bus.o_dbg_state = '0;
      for (int k = 0; k < C_CHANNELS; k++) begin
         bus.o_dbg_state[2*k +: 2] = state_q[k];
      end
   end

   assign bus.o_led      = led_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher: edge-mode DUT (a) and level-mode DUT (b), ON=4, OFF=3.
// Stimulus pushes hand-computed per-cycle expectations; a negedge monitor pops and compares.
module tb_led_pulse_stretcher;

   localparam int W = 20;
   localparam int N = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   led_pulse_stretcher_if #(.C_CHANNELS(4)) bus_a ();
   led_pulse_stretcher_if #(.C_CHANNELS(4)) bus_b ();

   led_pulse_stretcher #(
      .C_CHANNELS(4), .C_ON_TICKS(4), .C_OFF_TICKS(3), .C_CNT_WIDTH(2), .C_EDGE(1'b1)
   ) u_dut_a (
      .clk(clk), .i_rst(rst), .bus(bus_a.slave)
   );

   led_pulse_stretcher #(
      .C_CHANNELS(4), .C_ON_TICKS(4), .C_OFF_TICKS(3), .C_CNT_WIDTH(2), .C_EDGE(1'b0)
   ) u_dut_b (
      .clk(clk), .i_rst(rst), .bus(bus_b.slave)
   );

   logic [W-1:0] exp_a_q[$];
   logic [W-1:0] exp_b_q[$];
   int checks = 0;
   int errors = 0;
   int cur_test = 0;

   logic [3:0] ev_tab [N];
   logic       rst_tab[N];
   logic       clr_tab[N];
   logic [3:0] x_led  [N];
   logic [3:0] x_busy [N];
   logic [3:0] x_ovf  [N];

   task automatic clear_tabs();
      for (int e = 0; e < N; e++) begin
         ev_tab[e] = '0; rst_tab[e] = 1'b0; clr_tab[e] = 1'b0;
         x_led[e] = '0; x_busy[e] = '0; x_ovf[e] = '0;
      end
      rst_tab[0] = 1'b1;
   endtask

   // kind: 0 = event input, 1 = led, 2 = busy, 3 = overflow; marks edges a..b inclusive
   task automatic mark(input int kind, input int ch, input int a, input int b);
      for (int e = a; e <= b; e++) begin
         case (kind)
            0:       ev_tab[e][ch] = 1'b1;
            1:       x_led[e][ch]  = 1'b1;
            2:       x_busy[e][ch] = 1'b1;
            default: x_ovf[e][ch]  = 1'b1;
         endcase
      end
   endtask

   task automatic run_test(input int dut, input int len);
      for (int e = 0; e < len; e++) begin
         rst = rst_tab[e];
         if (dut == 0) begin
            bus_a.i_event = ev_tab[e]; bus_a.i_clr_overflow = clr_tab[e];
         end else begin
            bus_b.i_event = ev_tab[e]; bus_b.i_clr_overflow = clr_tab[e];
         end
         @(posedge clk);
         #1;
         if (dut == 0) exp_a_q.push_back({8'(e), x_led[e], x_busy[e], x_ovf[e]});
         else          exp_b_q.push_back({8'(e), x_led[e], x_busy[e], x_ovf[e]});
      end
      bus_a.i_event = '0; bus_a.i_clr_overflow = 1'b0;
      bus_b.i_event = '0; bus_b.i_clr_overflow = 1'b0;
      rst = 1'b0;
   endtask

   task automatic check(input string name, input logic [W-1:0] x, input logic [3:0] led,
                        input logic [3:0] busy, input logic [3:0] ovf, input logic [7:0] st);
      logic [7:0] es;
      es = '0;
      for (int k = 0; k < 4; k++) begin
         es[2*k +: 2] = x[8+k] ? 2'd1 : (x[4+k] ? 2'd2 : 2'd0);
      end
      checks++;
      if ({led, busy, ovf} !== x[11:0]) begin
         errors++;
         $display("FAIL %s_outputs test%0d edge%0d got led=%b busy=%b ovf=%b want led=%b busy=%b ovf=%b",
                  name, cur_test, x[19:12], led, busy, ovf, x[11:8], x[7:4], x[3:0]);
      end
      checks++;
      if (st !== es) begin
         errors++;
         $display("FAIL %s_state test%0d edge%0d got %b want %b", name, cur_test, x[19:12], st, es);
      end
   endtask

   always @(negedge clk) begin
      if (exp_a_q.size() > 0)
         check("dut_a", exp_a_q.pop_front(), bus_a.o_led, bus_a.o_busy, bus_a.o_overflow,
               bus_a.o_dbg_state);
      if (exp_b_q.size() > 0)
         check("dut_b", exp_b_q.pop_front(), bus_b.o_led, bus_b.o_busy, bus_b.o_overflow,
               bus_b.o_dbg_state);
   end

   initial begin
      bus_a.i_event = '0; bus_a.i_clr_overflow = 1'b0;
      bus_b.i_event = '0; bus_b.i_clr_overflow = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // 1: single pulse on ch0
      cur_test = 1; clear_tabs();
      mark(0, 0, 10, 10); mark(1, 0, 10, 13); mark(2, 0, 10, 16);
      run_test(0, 22);

      // 2: second pulse during ON is queued and replayed right after the gap
      cur_test = 2; clear_tabs();
      mark(0, 0, 10, 10); mark(0, 0, 12, 12);
      mark(1, 0, 10, 13); mark(1, 0, 17, 20); mark(2, 0, 10, 23);
      run_test(0, 27);

      // 3: level mode; third event overflows, clear, then clear coinciding with a new overflow
      cur_test = 3; clear_tabs();
      mark(0, 0, 10, 10); mark(0, 0, 12, 12); mark(0, 0, 13, 13);
      mark(1, 0, 10, 13); mark(1, 0, 17, 20); mark(2, 0, 10, 23);
      mark(3, 0, 13, 25); clr_tab[26] = 1'b1;
      mark(0, 0, 30, 30); mark(0, 0, 31, 31); mark(0, 0, 32, 32); clr_tab[32] = 1'b1;
      mark(1, 0, 30, 33); mark(1, 0, 37, 40); mark(2, 0, 30, 43);
      mark(3, 0, 32, 39); clr_tab[40] = 1'b1;
      run_test(1, 48);

      // 4a: held input in edge mode gives exactly one blink
      cur_test = 4; clear_tabs();
      mark(0, 1, 5, 24); mark(1, 1, 5, 8); mark(2, 1, 5, 11);
      run_test(0, 30);

      // 4b: held input in level mode blinks repeatedly and overflows
      cur_test = 5; clear_tabs();
      mark(0, 1, 5, 24);
      mark(1, 1, 5, 8); mark(1, 1, 12, 15); mark(1, 1, 19, 22); mark(1, 1, 26, 29);
      mark(2, 1, 5, 32); mark(3, 1, 7, 37);
      run_test(1, 38);

      // 5: reset cuts an active pulse; a later event behaves like a fresh one
      cur_test = 6; clear_tabs();
      mark(0, 0, 10, 10); rst_tab[12] = 1'b1;
      mark(1, 0, 10, 11); mark(2, 0, 10, 11);
      mark(0, 0, 20, 20); mark(1, 0, 20, 23); mark(2, 0, 20, 26);
      run_test(0, 30);

      // 6: all channels at once; ch2 retriggers on its last gap cycle, ch3 from idle later
      cur_test = 7; clear_tabs();
      for (int k = 0; k < 4; k++) begin
         mark(0, k, 5, 5); mark(1, k, 5, 8); mark(2, k, 5, 11);
      end
      mark(0, 2, 12, 12); mark(1, 2, 12, 15); mark(2, 2, 12, 18);
      mark(0, 3, 16, 16); mark(1, 3, 16, 19); mark(2, 3, 16, 22);
      run_test(0, 26);

      for (int i = 0; i < 10; i++) begin
         if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want 0", exp_a_q.size() + exp_b_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
